mbus_read_seq: RTL and testbench

Requester-side MBUS read-cycle sequencer sitting between the MBox cache-fill logic and the MBUS memory port. It accepts quadword read requests (address plus 4-bit word-request mask) and issues them alternately on MBUS phase A and phase B. For each phase it then runs the START/ACKN handshake, collects the VALID data words, checks parity and reports completion or timeout. At most one cycle is outstanding per phase, so two can overlap.

---
 rtl/mbus_read_seq_pkg.sv | 13 +
 rtl/mbus_read_seq_phase.sv | 64 ++++++
 rtl/mbus_read_seq.sv | 97 +++++++++
 tb/tb_mbus_read_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbus_read_seq_pkg.sv
// kl10pv: shared MBUS types and constants for the read-cycle sequencer
//   W36          data word width
//   MBUS_PHASES  number of interleaved MBUS phases (A, B)
//   tMbusPhaseSt per-phase read-cycle state
//   popcount4    number of words requested by a 4-bit mask
package kl10pv;
  localparam int W36 = 36;
  localparam int MBUS_PHASES = 2;
  typedef enum logic [1:0] {IDLE, START, DATA} tMbusPhaseSt;
  function automatic logic [2:0] popcount4(input logic [0:3] m);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction
endpackage

// File: rtl/mbus_read_seq_phase.sv
// mbus_phase_seq: one MBUS phase read cycle (START/ACKN, word count, timeout)
//   accept        load addr/rqIn and enter START
//   ackn, valid   raw MBUS ACKN / VALID for this phase
//   state         current phase state; adr/rq are the latched request
//   wo, last      word offset of the next word; next word ends the cycle
//   timeout       this edge aborts the cycle
module mbus_phase_seq
  import kl10pv::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         accept,
  input  logic [14:35] addr,
  input  logic [0:3]   rqIn,
  input  logic         ackn,
  input  logic         valid,
  output tMbusPhaseSt  state,
  output logic [14:35] adr,
  output logic [0:3]   rq,
  output logic [34:35] wo,
  output logic         last,
  output logic         timeout
);
  localparam int CW = $clog2(TIMEOUT + 1);
  tMbusPhaseSt nxt;
  logic [CW-1:0] cnt;
  logic [2:0] n;
  logic take, done;
  assign take = state == DATA && valid;
  assign last = n == 3'd1;
  assign done = take && last;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  // completion on the final word wins over a timeout on the same edge
  always_comb begin
    timeout = state != IDLE && !done && cnt == CW'(TIMEOUT - 1);
    nxt = state == IDLE ? (accept ? START : IDLE) :
          (timeout || done) ? IDLE :
          (state == START && ackn) ? DATA : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      adr <= '0;
      rq <= '0;
      wo <= '0;
      n <= '0;
      cnt <= '0;
    end else if (accept) begin
      adr <= addr;
      rq <= rqIn;
      wo <= addr[34:35];
      n <= popcount4(rqIn);
      cnt <= '0;
    end else begin
      if (state != IDLE) cnt <= cnt + CW'(1);
      if (take) begin
        wo <= wo + 2'd1;
        n <= n - 3'd1;
      end
    end
endmodule

// File: rtl/mbus_read_seq.sv
// mbus_read_seq: MBUS read sequencer issuing quadword reads alternately on phases A/B
//   req*      request handshake from cache-fill logic (addr, word mask)
//   start*/ackn*/validIn*, adr/adrHold/rq, dIn/parIn   MBUS memory port
//   rd*       returned word stream with offset, phase, parity error, last-word flag
//   errTimeout/errCollide  abort and dropped-B-word pulses
module mbus_read_seq
  import kl10pv::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           reqValid,
  output logic           reqReady,
  input  logic [14:35]   reqAddr,
  input  logic [0:3]     reqRq,
  output logic           startA,
  output logic           startB,
  input  logic           acknA,
  input  logic           acknB,
  input  logic           validInA,
  input  logic           validInB,
  output logic [14:35]   adr,
  output logic           adrHold,
  output logic [0:3]     rq,
  input  logic [0:W36-1] dIn,
  input  logic           parIn,
  output logic           rdValid,
  output logic [0:W36-1] rdData,
  output logic [34:35]   rdWord,
  output logic           rdPhase,
  output logic           rdParErr,
  output logic           rdDone,
  output logic           errTimeout,
  output logic           errCollide
);
  tMbusPhaseSt st [MBUS_PHASES];
  logic [14:35] padr [MBUS_PHASES];
  logic [0:3] prq [MBUS_PHASES];
  logic [34:35] pwo [MBUS_PHASES];
  logic [MBUS_PHASES-1:0] acc, ack, vin, last, to, pend;
  logic ptr, accept, va, vb;
  assign ack = {acknB, acknA};
  assign vin = {validInB, validInA};
  for (genvar p = 0; p < MBUS_PHASES; p++) begin : g_ph
    assign pend[p] = st[p] == START;
    assign acc[p] = accept && ptr == 1'(p);
    mbus_phase_seq #(.TIMEOUT(TIMEOUT)) u_ph (
      .clk(clk),
      .reset(reset),
      .accept(acc[p]),
      .addr(reqAddr),
      .rqIn(reqRq),
      .ackn(ack[p]),
      .valid(vin[p]),
      .state(st[p]),
      .adr(padr[p]),
      .rq(prq[p]),
      .wo(pwo[p]),
      .last(last[p]),
      .timeout(to[p])
    );
  end
  // only one START can be pending, so the address mux never has to arbitrate
  assign reqReady = st[ptr] == IDLE && pend == '0 && reqRq != '0;
  assign accept = reqValid && reqReady;
  assign startA = pend[0];
  assign startB = pend[1];
  assign adrHold = |pend;
  assign adr = pend[0] ? padr[0] : pend[1] ? padr[1] : '0;
  assign rq = pend[0] ? prq[0] : pend[1] ? prq[1] : '0;
  assign va = vin[0] && st[0] == DATA;
  assign vb = vin[1] && st[1] == DATA;
  // on a collision phase B still counts its word (inside its FSM) but it is not delivered
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ptr <= 1'b0;
      rdValid <= 1'b0;
      rdData <= '0;
      rdWord <= '0;
      rdPhase <= 1'b0;
      rdParErr <= 1'b0;
      rdDone <= 1'b0;
      errTimeout <= 1'b0;
      errCollide <= 1'b0;
    end else begin
      if (accept) ptr <= !ptr;
      rdValid <= va || vb;
      rdData <= (va || vb) ? dIn : '0;
      rdWord <= va ? pwo[0] : vb ? pwo[1] : '0;
      rdPhase <= !va && vb;
      rdParErr <= (va || vb) && (parIn ^ (^dIn));
      rdDone <= va ? last[0] : vb && last[1];
      errTimeout <= |to;
      errCollide <= va && vb;
    end
endmodule

// File: tb/tb_mbus_read_seq.sv
// tb_mbus_read_seq: directed stimulus against a transaction-level model of the read sequencer
module tb_mbus_read_seq;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reqValid = 1'b0, reqReady;
  logic [14:35] reqAddr = '0;
  logic [0:3] reqRq = '0;
  logic startA, startB, acknA = 1'b0, acknB = 1'b0, validInA = 1'b0, validInB = 1'b0;
  logic [14:35] adr;
  logic adrHold;
  logic [0:3] rq;
  logic [0:35] dIn = '0;
  logic parIn = 1'b0;
  logic rdValid, rdPhase, rdParErr, rdDone, errTimeout, errCollide;
  logic [0:35] rdData;
  logic [34:35] rdWord;

  mbus_read_seq #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
    .reqAddr(reqAddr), .reqRq(reqRq), .startA(startA), .startB(startB),
    .acknA(acknA), .acknB(acknB), .validInA(validInA), .validInB(validInB),
    .adr(adr), .adrHold(adrHold), .rq(rq), .dIn(dIn), .parIn(parIn),
    .rdValid(rdValid), .rdData(rdData), .rdWord(rdWord), .rdPhase(rdPhase),
    .rdParErr(rdParErr), .rdDone(rdDone), .errTimeout(errTimeout), .errCollide(errCollide)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // transaction model: one record per phase, timed by absolute cycle number
  bit [1:0] m_busy, m_acked;
  bit m_ptr;
  int m_left[2], m_wo[2], m_t0[2];
  logic [14:35] m_addr[2];
  logic [0:3] m_rq[2];
  int cyc_n = 0;
  bit e_valid, e_phase, e_par, e_done, e_to, e_col;
  logic [0:35] e_data;
  logic [1:0] e_word;

  function automatic bit m_ready();
    return !m_busy[m_ptr] && (m_busy & ~m_acked) == 2'b00 && reqRq != 4'b0000;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    bit [1:0] v, ak;
    bit rdy;
    int p;
    if (reset) begin
      m_busy = '0; m_acked = '0; m_ptr = 0;
      e_valid = 0; e_phase = 0; e_par = 0; e_done = 0; e_to = 0; e_col = 0;
      e_data = '0; e_word = '0;
    end else begin
      cyc_n++;
      rdy = m_ready();
      ak = {acknB, acknA};
      v[0] = validInA && m_busy[0] && m_acked[0];
      v[1] = validInB && m_busy[1] && m_acked[1];
      e_valid = |v;
      e_data = |v ? dIn : 36'd0;
      e_word = v[0] ? 2'(m_wo[0]) : v[1] ? 2'(m_wo[1]) : 2'd0;
      e_phase = !v[0] && v[1];
      e_par = |v && (parIn != ^dIn);
      e_done = v[0] ? m_left[0] == 1 : v[1] && m_left[1] == 1;
      e_col = &v;
      e_to = 0;
      for (int i = 0; i < 2; i++)
        if (m_busy[i]) begin
          if (v[i] && m_left[i] == 1) m_busy[i] = 0;
          else if (cyc_n - m_t0[i] == TO) begin
            m_busy[i] = 0;
            e_to = 1;
          end else begin
            if (ak[i]) m_acked[i] = 1;
            if (v[i]) begin
              m_left[i]--;
              m_wo[i] = (m_wo[i] + 1) % 4;
            end
          end
        end
      if (reqValid && rdy) begin
        p = int'(m_ptr);
        m_busy[p] = 1; m_acked[p] = 0;
        m_addr[p] = reqAddr; m_rq[p] = reqRq;
        m_wo[p] = int'(reqAddr[34:35]);
        m_left[p] = $countones(reqRq);
        m_t0[p] = cyc_n;
        m_ptr = !m_ptr;
      end
    end
  end

  function automatic logic [73:0] got_v();
    return {reqReady, startA, startB, adrHold, adr, rq, rdValid, rdData, rdWord,
            rdPhase, rdParErr, rdDone, errTimeout, errCollide};
  endfunction

  function automatic logic [73:0] exp_v();
    bit pa, pb;
    pa = m_busy[0] && !m_acked[0];
    pb = m_busy[1] && !m_acked[1];
    return {m_ready(), pa, pb, pa | pb, pa ? m_addr[0] : pb ? m_addr[1] : 22'd0,
            pa ? m_rq[0] : pb ? m_rq[1] : 4'd0, e_valid, e_data, e_word,
            e_phase, e_par, e_done, e_to, e_col};
  endfunction

  always @(negedge clk) check("cycle", got_v(), exp_v());

  logic [4:0] lq[$];
  int n_to = 0, n_col = 0, lbase = 0;
  always @(negedge clk) begin
    if (rdValid) lq.push_back({rdPhase, rdWord, rdDone, rdParErr});
    if (errTimeout) n_to++;
    if (errCollide) n_col++;
  end

  task automatic check_log(input string nm, input int n, input logic [63:0] e);
    logic [63:0] v = '0;
    check({nm, " count"}, 128'(lq.size() - lbase), 128'(n));
    for (int i = lbase; i < lq.size(); i++) v = (v << 5) | 64'(lq[i]);
    check(nm, v, e);
    lbase = lq.size();
  endtask

  task automatic cyc(); @(posedge clk); #2; endtask
  task automatic idle(input int n); repeat (n) cyc(); endtask
  task automatic req(input logic [14:35] a, input logic [0:3] r);
    reqValid = 1; reqAddr = a; reqRq = r;
    cyc();
    reqValid = 0; reqAddr = '0; reqRq = '0;
  endtask
  task automatic ack(input int p);
    if (p == 0) acknA = 1; else acknB = 1;
    cyc();
    acknA = 0; acknB = 0;
  endtask
  task automatic word(input int p, input logic [0:35] d, input bit bad);
    if (p == 0) validInA = 1; else validInB = 1;
    dIn = d; parIn = (^d) ^ bad;
    cyc();
    validInA = 0; validInB = 0; dIn = '0; parIn = 0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    reset = 0;
    check("reset startA", startA, 0);
    check("reset rdValid", rdValid, 0);
    reqValid = 1; reqAddr = 22'd5; reqRq = 4'b0000;
    #1 check("zero mask ready", reqReady, 0);
    cyc();
    reqValid = 0; reqAddr = '0;
    check("zero mask start", startA | startB, 0);
    // single quadword read on A
    req(22'o1000, 4'b1111);
    check("t1 startA", startA, 1);
    check("t1 adr", adr, 22'o1000);
    ack(0);
    check("t1 startA drop", startA, 0);
    for (int i = 0; i < 4; i++) word(0, 36'h912345678 + 36'(i), 0);
    idle(2);
    check_log("t1 words", 4, {5'd0, 5'd4, 5'd8, 5'd14});
    // two words from offset 2 go to B
    req(22'd2, 4'b1100);
    check("t2 startB", startB, 1);
    ack(1);
    for (int i = 0; i < 2; i++) word(1, 36'h0F0F0F0F0 ^ 36'(i * 3), 0);
    idle(2);
    check_log("t2 words", 2, {5'd24, 5'd30});
    // offset wraps 3 -> 0, then a single word on B
    req(22'd3, 4'b1111);
    ack(0);
    for (int i = 0; i < 4; i++) word(0, 36'hABCDE0123 + 36'(i * 17), 0);
    req(22'd1, 4'b1000);
    ack(1);
    word(1, 36'h000000001, 0);
    idle(2);
    check_log("t3 words", 5, {5'd12, 5'd0, 5'd4, 5'd10, 5'd22});
    // overlap: B accepted right after ackA while A data streams
    req(22'd0, 4'b0011);
    ack(0);
    reqValid = 1; reqAddr = 22'd1; reqRq = 4'b0110;
    validInA = 1; dIn = 36'h555555555; parIn = ^dIn;
    cyc();
    reqValid = 0; reqAddr = '0; reqRq = '0;
    check("t4 startB", startB, 1);
    dIn = 36'hAAAAAAAAA; parIn = ^dIn;
    cyc();
    validInA = 0;
    ack(1);
    word(1, 36'h123123123, 0);
    word(1, 36'h321321321, 0);
    idle(2);
    check_log("t4 words", 4, {5'd0, 5'd6, 5'd20, 5'd26});
    // no ackA: timeout, late VALID ignored, then A accepts again
    req(22'd0, 4'b0001);
    begin
      int i = 0;
      while (!errTimeout && i < 3 * TO) begin cyc(); i++; end
      check("t5 timeout latency", 128'(i), 128'(TO));
    end
    check("t5 startA after timeout", startA, 0);
    word(0, 36'h777777777, 0);
    req(22'd0, 4'b0001);
    ack(1);
    word(1, 36'h111111111, 0);
    req(22'd1, 4'b0001);
    check("t5 startA again", startA, 1);
    ack(0);
    word(0, 36'h222222222, 0);
    idle(2);
    check_log("t5 words", 2, {5'd18, 5'd6});
    // bad parity on word 1 only
    req(22'd0, 4'b1111);
    ack(1);
    for (int i = 0; i < 4; i++) word(1, 36'h0C0FFEE00 + 36'(i), i == 1);
    req(22'd0, 4'b0001);
    ack(0);
    word(0, 36'h333333333, 0);
    idle(2);
    check_log("t6 words", 5, {5'd16, 5'd21, 5'd24, 5'd30, 5'd2});
    // collision, then reset mid-DATA
    req(22'd0, 4'b1111);
    ack(1);
    req(22'd0, 4'b1111);
    ack(0);
    validInA = 1; validInB = 1; dIn = 36'h0F0F0F0F0; parIn = ^dIn;
    cyc();
    validInB = 0;
    check("t7 collide", errCollide, 1);
    check("t7 collide phase", rdPhase, 0);
    check("t7 collide valid", rdValid, 1);
    dIn = 36'h123456789; parIn = ^dIn;
    cyc();
    validInA = 0; dIn = '0; parIn = 0;
    check("t7 word before reset", rdValid, 1);
    #1 reset = 1;
    #1 check("t7 reset outputs", got_v(), 0);
    cyc();
    reset = 0;
    req(22'd0, 4'b0001);
    check("t7 pointer A", {startA, startB}, 2'b10);
    ack(0);
    word(0, 36'h444444444, 0);
    idle(2);
    check_log("t7 words", 2, {5'd0, 5'd2});
    check("timeout pulses", 128'(n_to), 128'(1));
    check("collide pulses", 128'(n_col), 128'(1));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
